// File: rtl/rr_arb_mux.sv
// ---------------------------------------------------------------------------
// rr_arb_mux
//   Round-robin arbiter fused with a one-hot data mux and one output register
//   stage. InputWidth requesters share a single downstream valid/ready channel.
//   The registered output sustains one beat per cycle.
//
// Optional feature (compile-time macro RR_ARB_MUX_PKT_LOCK_EN):
//   When defined, a beat accepted with last=0 locks arbitration onto that
//   requester until it delivers a beat with last=1 (packet-atomic transfers).
//   When undefined, arbitration is per beat and req_last_i is only forwarded.
//
// Ports:
//   clk          rising-edge clock
//   rstn         asynchronous active-low reset
//   req_valid_i  per-requester valid
//   req_data_i   per-requester payload
//   req_last_i   per-requester end-of-packet flag
//   req_ready_o  per-requester accept, one-hot or zero (combinational)
//   out_valid_o  registered output beat valid
//   out_data_o   registered output payload
//   out_last_o   registered last flag of the granted requester
//   out_ready_i  downstream accept
//   grant_oh_o   registered one-hot source of the current output beat
//
// Handshake semantics (both sides): a beat transfers on a rising edge where
// valid and ready are both high. Requesters may drop valid at any time; a
// withdrawn request is simply skipped. The output holds valid and all its
// fields stable while out_ready_i is low.
// ---------------------------------------------------------------------------
module rr_arb_mux #(
   parameter int InputWidth = 8,
   parameter int DataWidth  = 8
) (
   input  logic                                 clk,
   input  logic                                 rstn,
   input  logic [InputWidth-1:0]                req_valid_i,
   input  logic [InputWidth-1:0][DataWidth-1:0] req_data_i,
   input  logic [InputWidth-1:0]                req_last_i,
   output logic [InputWidth-1:0]                req_ready_o,
   output logic                                 out_valid_o,
   output logic [DataWidth-1:0]                 out_data_o,
   output logic                                 out_last_o,
   input  logic                                 out_ready_i,
   output logic [InputWidth-1:0]                grant_oh_o
);

   localparam int PtrW = (InputWidth > 1) ? $clog2(InputWidth) : 1;
   localparam int CntW = PtrW + 1;

   logic [PtrW-1:0]       ptr;
   logic                  slot_free;
   logic [InputWidth-1:0] eligible;
   logic                  win_found;
   logic [PtrW-1:0]       win_idx;
   logic [InputWidth-1:0] win_oh;
   logic [CntW-1:0]       cand;
   logic                  hs;
   logic [DataWidth-1:0]  mux_data;
   logic                  mux_last;
   logic [PtrW-1:0]       next_ptr;

`ifdef RR_ARB_MUX_PKT_LOCK_EN
   logic            locked;
   logic [PtrW-1:0] lock_idx;

   // While a packet is open only its owner may be granted; if the owner
   // withdraws valid nothing is granted and the lock stays in place.
   always_comb begin
      eligible = req_valid_i;
      if (locked) begin
         eligible = '0;
         eligible[lock_idx] = req_valid_i[lock_idx];
      end
   end
`else
   assign eligible = req_valid_i;
`endif

   // The output slot can take a new beat when it is empty or being drained.
   assign slot_free = !out_valid_o || out_ready_i;

   // Scan ptr, ptr+1, ... wrapping; the first eligible index wins. cand is one
   // bit wider than ptr so the wrap test cannot overflow.
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      cand      = '0;
      for (int j = 0; j < InputWidth; j++) begin
         cand = {1'b0, ptr} + CntW'(j);
         if (cand >= CntW'(InputWidth)) cand = cand - CntW'(InputWidth);
         if (!win_found && eligible[cand[PtrW-1:0]]) begin
            win_found = 1'b1;
            win_idx   = cand[PtrW-1:0];
         end
      end
      win_oh = '0;
      if (win_found) win_oh[win_idx] = 1'b1;
   end

   // Ready is suppressed during reset so nothing looks accepted while the
   // register stage is being cleared.
   assign req_ready_o = (slot_free && rstn) ? win_oh : '0;
   assign hs          = |req_ready_o;

   // One-hot AND-OR mux: at most one ready bit is set.
   always_comb begin
      mux_data = '0;
      mux_last = 1'b0;
      for (int i = 0; i < InputWidth; i++) begin
         if (req_ready_o[i]) begin
            mux_data = mux_data | req_data_i[i];
            mux_last = mux_last | req_last_i[i];
         end
      end
   end

   assign next_ptr = (win_idx == PtrW'(InputWidth - 1)) ? '0 : win_idx + 1'b1;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         out_valid_o <= 1'b0;
         out_data_o  <= '0;
         out_last_o  <= 1'b0;
         grant_oh_o  <= '0;
         ptr         <= '0;
`ifdef RR_ARB_MUX_PKT_LOCK_EN
         locked      <= 1'b0;
         lock_idx    <= '0;
`endif
      end else if (slot_free) begin
         if (hs) begin
            out_valid_o <= 1'b1;
            out_data_o  <= mux_data;
            out_last_o  <= mux_last;
            grant_oh_o  <= req_ready_o;
`ifdef RR_ARB_MUX_PKT_LOCK_EN
            if (!mux_last) begin
               // Opening (or continuing) a packet: pointer frozen while locked.
               if (!locked) begin
                  locked   <= 1'b1;
                  lock_idx <= win_idx;
                  ptr      <= next_ptr;
               end
            end else begin
               // Closing beat (or single-beat packet) releases the lock and
               // hands priority to the requester after the owner.
               locked <= 1'b0;
               ptr    <= next_ptr;
            end
`else
            ptr <= next_ptr;
`endif
         end else begin
            // Drained with nothing to load: data/last/grant keep stale values.
            out_valid_o <= 1'b0;
         end
      end
   end

endmodule

// File: doc/rr_arb_mux.md
# rr_arb_mux

Round-robin arbiter fused with a one-hot data mux and a single output register stage. It shares one downstream valid/ready channel between `InputWidth` requesters. Each accepted beat is steered by a one-hot grant and registered onto the output, so the channel sustains one beat per cycle. It sits in front of any shared consumer port in the FU datapath (writeback, issue, memory request) that today is fed by a bare one-hot mux.

## Interface
Parameters:
- `InputWidth`, 8: number of requesters, at least 2.
- `DataWidth`, 8: payload width.

Ports:
- `clk`  in  1  clock, rising edge.
- `rstn`  in  1  reset, asynchronous, active-low.
- `req_valid_i`  in  `InputWidth`  per-requester valid.
- `req_data_i`  in  `[InputWidth-1:0][DataWidth-1:0]`  per-requester payload.
- `req_last_i`  in  `InputWidth`  per-requester end-of-packet flag.
- `req_ready_o`  out  `InputWidth`  per-requester accept; one-hot or zero.
- `out_valid_o`  out  1  output beat valid, registered.
- `out_data_o`  out  `DataWidth`  output payload, registered.
- `out_last_o`  out  1  registered `req_last_i` of the granted requester.
- `out_ready_i`  in  1  downstream accept.
- `grant_oh_o`  out  `InputWidth`  registered one-hot source of the current output beat.

## Operation
- Internal state:
  - `ptr`: priority index, `$clog2(InputWidth)` bits.
  - Output register: valid, data, last, grant.
  - Lock state, only when the macro is enabled.
- `slot_free` = `!out_valid_o || out_ready_i`.
- Winner = first index `i` with `req_valid_i[i]=1`, scanning `ptr, ptr+1, …, InputWidth-1, 0, …, ptr-1`.
- `req_ready_o` = one-hot(winner) & {InputWidth{slot_free}}. It is combinational and is zero when no request is valid.
- Handshake `k` = `req_valid_i[k] && req_ready_o[k]`. On handshake, the output register loads the one-hot-muxed `req_data_i[k]` and `req_last_i[k]`, sets `grant_oh_o = 1<<k`, and sets `out_valid_o = 1`.
- On `slot_free` with no valid request, `out_valid_o <= 0`. Data, last and grant hold their previous values (don't-care).
- When `out_valid_o && !out_ready_i`, all output fields are held and `req_ready_o = 0`.
- Pointer update on handshake `k`: `ptr <= (k+1) mod InputWidth`, wrapping from `InputWidth-1` to 0. No handshake means `ptr` holds.
- The arbiter never requires a requester to hold valid. A withdrawn request is simply skipped.
- Reset values: `out_valid_o=0`, `out_data_o=0`, `out_last_o=0`, `grant_oh_o=0`, `ptr=0`, lock cleared.

## Timing
- Latency: a handshake in cycle N gives `out_valid_o` and data in cycle N+1.
- Throughput: 1 beat/cycle while `out_ready_i=1`.
- Bubble-free: an accept on the output and a load of a new beat happen in the same cycle.
- Reset asserted mid-stream clears the output register and `ptr` immediately. The in-flight beat is dropped.
- First rising edge after `rstn` deasserts: arbitration resumes from index 0.

## Configuration
- Macro: `RR_ARB_MUX_PKT_LOCK_EN`.
- Defined:
  - A handshake with `req_last_i[k]=0` sets `locked=1` and `lock_idx=k`.
  - While locked, only `lock_idx` is eligible. Other valid requesters get `req_ready_o=0`.
  - While locked, `ptr` does not advance.
  - A handshake of `lock_idx` with `req_last_i=1` clears `locked` and sets `ptr <= lock_idx+1`.
  - If the locked requester drops valid, nothing is granted and the lock persists.
- Undefined:
  - No lock state exists. Arbitration is per beat.
  - `req_last_i` is only forwarded to `out_last_o`.

## Test plan
- Reset with `rstn=0`, all requests valid → all outputs 0 and `req_ready_o=0`. After release with `out_ready_i=1`, the first grant is index 0.
- All 8 valid, payloads `0x10+i`, `out_ready_i=1` → `grant_oh_o` sequence `0x01,0x02,…,0x80,0x01` on consecutive cycles, `out_data_o` matching, no bubbles.
- `ptr=3`, only requesters 2 and 5 valid → requester 5 is granted first, then 2, then 5.
- Output valid with `out_ready_i=0` for 3 cycles → `out_data_o`/`grant_oh_o` stable, `req_ready_o=0`, `ptr` unchanged. Release → next beat loads in the same cycle.
- Requester 0 sends a 3-beat packet (last on beat 3) while requester 1 is always valid.
  - Macro defined → grants 0,0,0,1.
  - Macro undefined → grants 0,1,0,1,0.
- `rstn` pulsed low mid-stream → `out_valid_o` drops asynchronously before the next edge. After release, grants restart at index 0.
